// File: rtl/whack_round_ctrl.sv
`default_nettype none
// ---- whack_round_ctrl: session/round sequencer for whack-a-mole (rev 1.0) ----
// Owns game/round timers and miss budget, handshakes patterns, judges presses.

module whack_round_ctrl #(
  parameter int unsigned GAME_TICKS = 60000,
  parameter int unsigned ROUND_T0   = 5000,
  parameter int unsigned ROUND_T1   = 4000,
  parameter int unsigned ROUND_T2   = 3000,
  parameter int unsigned ROUND_T3   = 2000,
  parameter int unsigned GAP_TICKS  = 16,
  parameter int unsigned MAX_MISSES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] btn,
  input  logic       pat_ack,
  input  logic [6:0] pat_data,
  output logic       pat_req,
  output logic [2:0] num_lit,
  output logic [6:0] pattern_shown,
  output logic [6:0] lockout,
  output logic [7:0] score,
  output logic [2:0] misses,
  output logic       playing,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  localparam logic [15:0] c_game_ticks = 16'(GAME_TICKS);
  localparam logic [15:0] c_round_t0   = 16'(ROUND_T0);
  localparam logic [15:0] c_round_t1   = 16'(ROUND_T1);
  localparam logic [15:0] c_round_t2   = 16'(ROUND_T2);
  localparam logic [15:0] c_round_t3   = 16'(ROUND_T3);
  localparam logic [15:0] c_gap_last   = 16'(GAP_TICKS - 1);
  localparam logic [2:0]  c_max_misses = 3'(MAX_MISSES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_SHOW = 3'd2,
    ST_GAP  = 3'd3,
    ST_OVER = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        start_q;
  logic [15:0] game_tmr_q, game_tmr_d;
  logic [15:0] round_tmr_q, round_tmr_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [6:0]  pattern_q, pattern_d;
  logic [6:0]  lockout_q, lockout_d;
  logic [7:0]  score_q, score_d;
  logic [2:0]  misses_q, misses_d;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;

  logic        w_start_edge;
  logic        w_live;
  logic        w_expired;
  logic [1:0]  w_level;
  logic [15:0] w_round_load;
  logic [6:0]  w_eff;
  logic [6:0]  w_wrong;
  logic        w_hit;
  logic [2:0]  w_misses_inc;

  assign w_start_edge = start & ~start_q;
  assign w_live       = (state_q == ST_REQ) | (state_q == ST_SHOW) | (state_q == ST_GAP);
  assign w_expired    = w_live & (game_tmr_q == 16'd0);
  assign w_eff        = btn & ~lockout_q;
  assign w_wrong      = w_eff & ~pattern_q;
  assign w_hit        = ((w_eff & pattern_q) == pattern_q);
  assign w_misses_inc = misses_q + 3'd1;

  always_comb begin
    if (score_q < 8'd5)       w_level = 2'd0;
    else if (score_q < 8'd10) w_level = 2'd1;
    else if (score_q < 8'd20) w_level = 2'd2;
    else                      w_level = 2'd3;
  end

  always_comb begin
    case (w_level)
      2'd0:    w_round_load = c_round_t0;
      2'd1:    w_round_load = c_round_t1;
      2'd2:    w_round_load = c_round_t2;
      default: w_round_load = c_round_t3;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    game_tmr_d  = game_tmr_q;
    round_tmr_d = round_tmr_q;
    gap_cnt_d   = gap_cnt_q;
    pattern_d   = pattern_q;
    lockout_d   = lockout_q;
    score_d     = score_q;
    misses_d    = misses_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;

    if (w_live && (game_tmr_q != 16'd0)) game_tmr_d = game_tmr_q - 16'd1;

    // Game expiry overrides everything else in any playing state.
    if (w_expired) begin
      state_d   = ST_OVER;
      pattern_d = 7'd0;
      lockout_d = 7'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (w_start_edge) begin
            score_d    = 8'd0;
            misses_d   = 3'd0;
            lockout_d  = 7'd0;
            game_tmr_d = c_game_ticks;
            state_d    = ST_REQ;
          end
        end
        ST_REQ: begin
          if (pat_ack) begin
            pattern_d   = (pat_data == 7'd0) ? 7'b0000001 : pat_data;
            round_tmr_d = w_round_load;
            lockout_d   = 7'd0;
            state_d     = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (w_hit) begin
            score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            hit_d     = 1'b1;
            pattern_d = 7'd0;
            gap_cnt_d = 16'd0;
            state_d   = ST_GAP;
          end else if (|w_wrong) begin
            lockout_d = lockout_q | w_wrong;
          end else if (round_tmr_q == 16'd0) begin
            misses_d  = w_misses_inc;
            miss_d    = 1'b1;
            pattern_d = 7'd0;
            if (w_misses_inc == c_max_misses) begin
              lockout_d = 7'd0;
              state_d   = ST_OVER;
            end else begin
              gap_cnt_d = 16'd0;
              state_d   = ST_GAP;
            end
          end else begin
            round_tmr_d = round_tmr_q - 16'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == c_gap_last) state_d = ST_REQ;
          else                         gap_cnt_d = gap_cnt_q + 16'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      game_tmr_q  <= 16'd0;
      round_tmr_q <= 16'd0;
      gap_cnt_q   <= 16'd0;
      pattern_q   <= 7'd0;
      lockout_q   <= 7'd0;
      score_q     <= 8'd0;
      misses_q    <= 3'd0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      game_tmr_q  <= game_tmr_d;
      round_tmr_q <= round_tmr_d;
      gap_cnt_q   <= gap_cnt_d;
      pattern_q   <= pattern_d;
      lockout_q   <= lockout_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign pat_req       = (state_q == ST_REQ);
  assign num_lit       = {1'b0, w_level} + 3'd1;
  assign pattern_shown = pattern_q;
  assign lockout       = lockout_q;
  assign score         = score_q;
  assign misses        = misses_q;
  assign playing       = w_live;
  assign game_over     = (state_q == ST_OVER);
  assign hit_pulse     = hit_q;
  assign miss_pulse    = miss_q;

endmodule

`default_nettype wire

// File: tb/tb_whack_round_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---- tb_whack_round_ctrl: lockstep reference model plus directed/table rounds (rev 1.0) ----

module tb_whack_round_ctrl;

  localparam int GAME = 300;
  localparam int GAP  = 4;
  localparam int MAXM = 3;
  localparam int P_IDLE = 0, P_REQ = 1, P_SHOW = 2, P_GAP = 3, P_OVER = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] btn = 7'd0;
  logic       pat_ack = 1'b0;
  logic [6:0] pat_data;
  logic       pat_req;
  logic [2:0] num_lit;
  logic [6:0] pattern_shown, lockout;
  logic [7:0] score;
  logic [2:0] misses;
  logic       playing, game_over, hit_pulse, miss_pulse;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  whack_round_ctrl #(
    .GAME_TICKS(GAME), .ROUND_T0(20), .ROUND_T1(16), .ROUND_T2(12), .ROUND_T3(8),
    .GAP_TICKS(GAP), .MAX_MISSES(MAXM)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .pat_ack(pat_ack), .pat_data(pat_data),
    .pat_req(pat_req), .num_lit(num_lit), .pattern_shown(pattern_shown), .lockout(lockout),
    .score(score), .misses(misses), .playing(playing), .game_over(game_over),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  // Second instance with a long game and 1-cycle gap, used only to reach score saturation.
  logic       s_rst = 1'b1, s_start = 1'b0, s_req, s_playing, s_over, s_hit, s_miss;
  logic [6:0] s_btn, s_shown, s_lockout, s_pat;
  logic [2:0] s_numlit, s_misses;
  logic [7:0] s_score;
  bit         sat_done = 1'b0;
  assign s_btn = s_shown;
  assign s_pat = 7'b0000001;

  whack_round_ctrl #(.GAME_TICKS(60000), .GAP_TICKS(1)) u_sat (
    .clk(clk), .rst(s_rst), .start(s_start), .btn(s_btn), .pat_ack(s_req), .pat_data(s_pat),
    .pat_req(s_req), .num_lit(s_numlit), .pattern_shown(s_shown), .lockout(s_lockout),
    .score(s_score), .misses(s_misses), .playing(s_playing), .game_over(s_over),
    .hit_pulse(s_hit), .miss_pulse(s_miss)
  );

  // Pattern generator: acks on the third cycle of a request.
  logic [6:0] gen_pat = 7'd0, rnd_pat = 7'd0;
  bit         rand_mode = 1'b0;
  int         req_age = 0;
  assign pat_data = rand_mode ? rnd_pat : gen_pat;

  always @(posedge clk) begin
    #1;
    req_age = pat_req ? req_age + 1 : 0;
    pat_ack = (req_age == 3) || (rand_mode && ($urandom % 16 == 0));
    rnd_pat = ($urandom % 8 == 0) ? 7'd0 : 7'($urandom);
  end

  function automatic int lvl(input int s);
    if (s < 5) return 0;
    if (s < 10) return 1;
    if (s < 20) return 2;
    return 3;
  endfunction

  function automatic int window(input int l);
    return 20 - 4 * l;
  endfunction

  // Reference model of the game rules, advanced once per clock.
  int         m_ph, m_gt, m_rt, m_gap, m_score, m_miss;
  logic [6:0] m_pat, m_lock, m_eff;
  bit         m_hit, m_missp, m_sq, m_edge, m_live, m_expired;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = P_IDLE; m_gt = 0; m_rt = 0; m_gap = 0; m_score = 0; m_miss = 0;
      m_pat = 7'd0; m_lock = 7'd0; m_hit = 1'b0; m_missp = 1'b0; m_sq = 1'b0;
    end else begin
      m_edge = start && !m_sq;
      m_sq = start;
      m_hit = 1'b0;
      m_missp = 1'b0;
      m_live = (m_ph == P_REQ) || (m_ph == P_SHOW) || (m_ph == P_GAP);
      m_expired = m_live && (m_gt == 0);
      if (m_live && m_gt > 0) m_gt = m_gt - 1;
      if (m_expired) begin
        m_ph = P_OVER; m_pat = 7'd0; m_lock = 7'd0;
      end else begin
        case (m_ph)
          P_IDLE, P_OVER:
            if (m_edge) begin
              m_score = 0; m_miss = 0; m_lock = 7'd0; m_gt = GAME; m_ph = P_REQ;
            end
          P_REQ:
            if (pat_ack) begin
              m_pat = (pat_data == 7'd0) ? 7'd1 : pat_data;
              m_rt = window(lvl(m_score));
              m_lock = 7'd0;
              m_ph = P_SHOW;
            end
          P_SHOW: begin
            m_eff = btn & ~m_lock;
            if ((m_eff & m_pat) == m_pat) begin
              m_score = (m_score < 255) ? m_score + 1 : 255;
              m_hit = 1'b1; m_ph = P_GAP; m_pat = 7'd0; m_gap = 0;
            end else if ((m_eff & ~m_pat) != 7'd0) begin
              m_lock = m_lock | (m_eff & ~m_pat);
            end else if (m_rt == 0) begin
              m_miss = m_miss + 1;
              m_missp = 1'b1;
              m_pat = 7'd0;
              if (m_miss == MAXM) begin
                m_ph = P_OVER; m_lock = 7'd0;
              end else begin
                m_ph = P_GAP; m_gap = 0;
              end
            end else begin
              m_rt = m_rt - 1;
            end
          end
          P_GAP: begin
            m_gap = m_gap + 1;
            if (m_gap == GAP) m_ph = P_REQ;
          end
          default: ;
        endcase
      end
    end
  end

  wire  [32:0] dut_vec = {pat_req, num_lit, pattern_shown, lockout, score, misses,
                          playing, game_over, hit_pulse, miss_pulse};
  logic [32:0] exp_vec;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_vec = {m_ph == P_REQ, 3'(lvl(m_score) + 1), m_pat, m_lock, 8'(m_score), 3'(m_miss),
                 (m_ph == P_REQ) || (m_ph == P_SHOW) || (m_ph == P_GAP), m_ph == P_OVER,
                 m_hit, m_missp};
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL lockstep t=%0t actual=%h required=%h", $time, dut_vec, exp_vec);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_shown();
    int n = 0;
    while (pattern_shown == 7'd0 && !game_over && n < 200) begin
      tick();
      n++;
    end
    check("wait_shown", 32'(pattern_shown != 7'd0), 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pat_req"}, pat_req, 0);
    check({tag, "_num_lit"}, num_lit, 1);
    check({tag, "_pattern"}, pattern_shown, 0);
    check({tag, "_lockout"}, lockout, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_misses"}, misses, 0);
    check({tag, "_playing"}, playing, 0);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_pulses"}, {hit_pulse, miss_pulse}, 0);
  endtask

  typedef struct {
    logic [6:0] pat;
    logic [6:0] press1;
    logic [6:0] press2;
    logic [6:0] shown;
    logic [7:0] score;
    logic [6:0] lock;
    logic [2:0] nlit;
  } round_vec_t;

  round_vec_t tbl[5];

  initial begin
    int n, show_start;
    bit seen20, missdone;
    tbl[0] = '{7'b0000011, 7'b0100000, 7'b0100011, 7'b0000011, 8'd2, 7'b0100000, 3'd1};
    tbl[1] = '{7'b0000000, 7'b0000001, 7'b0000000, 7'b0000001, 8'd3, 7'b0000000, 3'd1};
    tbl[2] = '{7'b1110000, 7'b0001111, 7'b1111111, 7'b1110000, 8'd4, 7'b0001111, 3'd1};
    tbl[3] = '{7'b1010101, 7'b0000000, 7'b1010101, 7'b1010101, 8'd5, 7'b0000000, 3'd2};
    tbl[4] = '{7'b0110110, 7'b1001001, 7'b0110110, 7'b0110110, 8'd6, 7'b1001001, 3'd2};

    #2 rst = 1'b1;
    chk_en = 1'b1;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();
    check("idle_no_req", pat_req, 0);

    // First round: hit, then exactly GAP blank cycles before the next request.
    gen_pat = 7'b0000101;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_req", pat_req, 1);
    check("start_playing", playing, 1);
    wait_shown();
    check("r1_shown", pattern_shown, 7'b0000101);
    btn = 7'b0000101;
    tick();
    btn = 7'd0;
    gen_pat = tbl[0].pat;
    check("r1_hit_pulse", hit_pulse, 1);
    check("r1_score", score, 1);
    for (int k = 0; k < GAP; k++) begin
      check("gap_blank", pattern_shown, 0);
      check("gap_no_req", pat_req, 0);
      if (k == 1) check("hit_pulse_one_cycle", hit_pulse, 0);
      tick();
    end
    check("gap_then_req", pat_req, 1);

    for (int i = 0; i < 5; i++) begin
      wait_shown();
      check("tbl_shown", pattern_shown, tbl[i].shown);
      btn = tbl[i].press1;
      tick();
      btn = tbl[i].press2;
      tick();
      btn = 7'd0;
      gen_pat = (i < 4) ? tbl[i + 1].pat : 7'b0011000;
      check("tbl_score", score, tbl[i].score);
      check("tbl_lockout", lockout, tbl[i].lock);
      check("tbl_num_lit", num_lit, tbl[i].nlit);
    end

    // Level 1 window then miss budget exhaustion.
    wait_shown();
    n = 0;
    while (!miss_pulse && n < 100) begin
      tick();
      n++;
    end
    check("window16_cycles", n, 17);
    check("miss1_count", misses, 1);
    for (int j = 0; j < 2; j++) begin
      wait_shown();
      n = 0;
      while (!miss_pulse && n < 100) begin
        tick();
        n++;
      end
      check("miss_pulse_seen", miss_pulse, 1);
    end
    check("over_game_over", game_over, 1);
    check("over_misses", misses, 3);
    check("over_playing", playing, 0);
    check("over_score_held", score, 6);

    // Restart, hit continuously, one level-3 miss, run into game expiry.
    gen_pat = 7'b1000001;
    start = 1'b1;
    tick();
    n = 0; show_start = -1; seen20 = 1'b0; missdone = 1'b0;
    while (!game_over && n < 400) begin
      if (score == 8'd20 && !seen20) begin
        check("score20_num_lit", num_lit, 4);
        seen20 = 1'b1;
      end
      if (score >= 8'd20 && !missdone && pattern_shown != 7'd0 && show_start < 0) show_start = n;
      if (miss_pulse && !missdone) begin
        check("window8_cycles", n - show_start, 9);
        missdone = 1'b1;
      end
      btn = (score >= 8'd20 && !missdone) ? 7'd0 : pattern_shown;
      tick();
      n++;
    end
    btn = 7'd0;
    check("expiry_cycle", n, GAME + 1);
    check("expiry_game_over", game_over, 1);
    check("reached_score20", seen20, 1);
    repeat (10) tick();
    check("held_start_no_restart", game_over, 1);
    check("over_not_playing", playing, 0);
    check("over_blank", pattern_shown, 0);
    check("over_lockout_clear", lockout, 0);
    start = 1'b0;
    tick();

    // Asynchronous reset in the middle of a SHOW round.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      wait_shown();
      btn = pattern_shown;
      tick();
      btn = 7'd0;
    end
    wait_shown();
    check("pre_reset_score", score, 3);
    rst = 1'b1;
    #1;
    check_reset("mid_reset");
    tick();
    rst = 1'b0;
    repeat (5) begin
      tick();
      check("post_reset_idle", playing, 0);
      check("post_reset_no_req", pat_req, 0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("post_reset_start", pat_req, 1);

    // Randomised play against the lockstep model.
    rand_mode = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      case ($urandom % 4)
        0: btn = 7'd0;
        1: btn = 7'($urandom);
        2: btn = pattern_shown;
        default: btn = pattern_shown | (7'($urandom) & 7'($urandom));
      endcase
      start = ($urandom % 40 == 0);
      if ($urandom % 600 == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    rand_mode = 1'b0;
    btn = 7'd0;
    start = 1'b0;

    n = 0;
    while (!sat_done && n < 5000) begin
      tick();
      n++;
    end
    check("sat_done", sat_done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n, hits;
    repeat (2) @(posedge clk);
    #1 s_rst = 1'b0;
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    n = 0;
    while (s_score != 8'd255 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("sat_reach_255", s_score, 255);
    hits = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (s_hit) hits++;
    end
    check("sat_hold_255", s_score, 255);
    check("sat_hits_continue", 32'(hits > 0), 1);
    check("sat_num_lit", s_numlit, 4);
    check("sat_misses", s_misses, 0);
    check("sat_lockout", s_lockout, 0);
    check("sat_flags", {s_playing, s_over, s_miss}, 3'b100);
    sat_done = 1'b1;
  end

endmodule

`default_nettype wire
